// File: rtl/ubtb_update_ctrl_if.sv
// ubtb_update_ctrl_if: request, flush, fetch-read and uBTB write-port bundle for the update scheduler
interface ubtb_update_ctrl_if #(
    parameter int MXLEN  = 32,
    parameter int QDEPTH = 4
);
    logic                      i_cmt_valid;
    logic [MXLEN-1:0]          i_cmt_src;
    logic [MXLEN-1:0]          i_cmt_dst;
    logic                      o_cmt_ready;
    logic                      i_dec_valid;
    logic [MXLEN-1:0]          i_dec_src;
    logic [MXLEN-1:0]          i_dec_dst;
    logic                      o_dec_ready;
    logic                      i_flush;
    logic                      i_pc_valid;
    logic [MXLEN-1:0]          i_pc;
    logic                      o_ubtb_update;
    logic [MXLEN-1:0]          o_pc_jumpsrc;
    logic [MXLEN-1:0]          o_pc_jumpdst;
    logic [$clog2(QDEPTH):0]   o_q_count;

    modport master (
        output i_cmt_valid, i_cmt_src, i_cmt_dst, i_dec_valid, i_dec_src, i_dec_dst,
               i_flush, i_pc_valid, i_pc,
        input  o_cmt_ready, o_dec_ready, o_ubtb_update, o_pc_jumpsrc, o_pc_jumpdst, o_q_count
    );
    modport slave (
        input  i_cmt_valid, i_cmt_src, i_cmt_dst, i_dec_valid, i_dec_src, i_dec_dst,
               i_flush, i_pc_valid, i_pc,
        output o_cmt_ready, o_dec_ready, o_ubtb_update, o_pc_jumpsrc, o_pc_jumpdst, o_q_count
    );
endinterface

// File: rtl/ubtb_update_ctrl.sv
// ubtb_update_ctrl: coalescing update queue feeding the uBTB write port, commit over decode,
// with bounded deferral while the fetch read hits the same uBTB index
module ubtb_update_ctrl #(
    parameter int MXLEN     = 32,
    parameter int QDEPTH    = 4,
    parameter int IDX_LSB   = 2,
    parameter int IDX_W     = 4,
    parameter int STALL_MAX = 3
) (
    input logic               i_clk,
    input logic               i_rstn,
    ubtb_update_ctrl_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [MXLEN-1:0] IDX_MASK = ((MXLEN'(1) << IDX_W) - MXLEN'(1)) << IDX_LSB;

    logic [MXLEN-1:0] src_q [QDEPTH];
    logic [MXLEN-1:0] dst_q [QDEPTH];
    logic [PW-1:0]    head, tail, hit_idx;
    logic [CW-1:0]    count;
    logic [SW-1:0]    stall_cnt;
    logic             cmt_rdy, cmt_acc, acc, empty, hazard, deq, enq, hit;
    logic [MXLEN-1:0] req_src, req_dst;

    assign empty   = count == '0;
    assign cmt_rdy = (count < CW'(QDEPTH)) & ~bus.i_flush & i_rstn;
    assign cmt_acc = bus.i_cmt_valid & cmt_rdy;
    assign acc     = cmt_acc | (bus.i_dec_valid & cmt_rdy & ~bus.i_cmt_valid);
    assign req_src = cmt_acc ? bus.i_cmt_src : bus.i_dec_src;
    assign req_dst = cmt_acc ? bus.i_cmt_dst : bus.i_dec_dst;
    // masked full-width compare keeps the index bits selectable by parameter
    assign hazard  = bus.i_pc_valid & ~|((bus.i_pc ^ src_q[head]) & IDX_MASK);
    assign deq     = ~empty & ~bus.i_flush & (~hazard | stall_cnt == SW'(STALL_MAX));
    assign enq     = acc & ~hit;

    assign bus.o_cmt_ready   = cmt_rdy;
    assign bus.o_dec_ready   = cmt_rdy & ~bus.i_cmt_valid;
    assign bus.o_ubtb_update = deq;
    assign bus.o_pc_jumpsrc  = empty ? '0 : src_q[head];
    assign bus.o_pc_jumpdst  = empty ? '0 : dst_q[head];
    assign bus.o_q_count     = count;

    // the head leaving this cycle is excluded so a late match re-enqueues at tail
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ({1'b0, PW'(i) - head} < count && !(deq && PW'(i) == head) && src_q[i] == req_src) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
            end
        end else if (bus.i_flush) begin
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            stall_cnt <= '0;
        end else begin
            count     <= count + CW'(enq) - CW'(deq);
            stall_cnt <= (empty | deq) ? '0 : stall_cnt + 1'b1;
            if (deq) head <= head + 1'b1;
            if (enq) begin
                tail         <= tail + 1'b1;
                src_q[tail]  <= req_src;
                dst_q[tail]  <= req_dst;
            end
            if (acc & hit) dst_q[hit_idx] <= req_dst;
        end
    end
endmodule

// File: tb/tb_ubtb_update_ctrl.sv
// tb_ubtb_update_ctrl: directed and random stimulus against a queue-based reference model
module tb_ubtb_update_ctrl;
    localparam int MXLEN = 32, QDEPTH = 4;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
    } ent_t;

    logic i_clk = 1'b0;
    logic i_rstn = 1'b0;
    int   total = 0, bad = 0;
    ent_t q[$];
    int   stall = 0;

    ubtb_update_ctrl_if #(.MXLEN(MXLEN), .QDEPTH(QDEPTH)) bus ();
    ubtb_update_ctrl #(.MXLEN(MXLEN), .QDEPTH(QDEPTH), .IDX_LSB(2), .IDX_W(4), .STALL_MAX(3))
        dut (.i_clk(i_clk), .i_rstn(i_rstn), .bus(bus));

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic cv, input logic [31:0] cs, input logic [31:0] cd,
                         input logic dv, input logic [31:0] ds, input logic [31:0] dd,
                         input logic fl, input logic pv, input logic [31:0] pc);
        bus.i_cmt_valid = cv; bus.i_cmt_src = cs; bus.i_cmt_dst = cd;
        bus.i_dec_valid = dv; bus.i_dec_src = ds; bus.i_dec_dst = dd;
        bus.i_flush = fl; bus.i_pc_valid = pv; bus.i_pc = pc;
    endtask

    task automatic step(input logic cv, input logic [31:0] cs, input logic [31:0] cd,
                        input logic dv, input logic [31:0] ds, input logic [31:0] dd,
                        input logic fl, input logic pv, input logic [31:0] pc);
        logic [31:0] hs, hd;
        logic cr, dr, haz, upd;
        ent_t r;
        int m;
        @(negedge i_clk);
        drive(cv, cs, cd, dv, ds, dd, fl, pv, pc);
        #1;
        hs  = q.size() != 0 ? q[0].src : 32'h0;
        hd  = q.size() != 0 ? q[0].dst : 32'h0;
        cr  = q.size() < QDEPTH && !fl;
        dr  = cr && !cv;
        haz = pv && ((pc / 4) % 16 == (hs / 4) % 16);
        upd = q.size() != 0 && !fl && (!haz || stall == 3);
        chk("cmt_ready", 64'(bus.o_cmt_ready), 64'(cr));
        chk("dec_ready", 64'(bus.o_dec_ready), 64'(dr));
        chk("update", 64'(bus.o_ubtb_update), 64'(upd));
        chk("jumpsrc", 64'(bus.o_pc_jumpsrc), 64'(hs));
        chk("jumpdst", 64'(bus.o_pc_jumpdst), 64'(hd));
        chk("q_count", 64'(bus.o_q_count), 64'(q.size()));
        @(posedge i_clk);
        if (fl) begin
            q.delete();
            stall = 0;
        end else begin
            stall = (upd || q.size() == 0) ? 0 : stall + 1;
            if (upd) void'(q.pop_front());
            if (cr && (cv || dv)) begin
                r.src = cv ? cs : ds;
                r.dst = cv ? cd : dd;
                m = -1;
                foreach (q[i]) if (q[i].src == r.src) m = i;
                if (m >= 0) q[m].dst = r.dst;
                else q.push_back(r);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_upd"}, 64'(bus.o_ubtb_update), 64'h0);
        chk({tag, "_cnt"}, 64'(bus.o_q_count), 64'h0);
        chk({tag, "_src"}, 64'(bus.o_pc_jumpsrc), 64'h0);
        chk({tag, "_dst"}, 64'(bus.o_pc_jumpdst), 64'h0);
        chk({tag, "_crdy"}, 64'(bus.o_cmt_ready), 64'h0);
        chk({tag, "_drdy"}, 64'(bus.o_dec_ready), 64'h0);
    endtask

    initial begin
        logic [31:0] cs, ds;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_zero("reset");
        @(negedge i_clk);
        i_rstn = 1'b1;

        step(1, 32'h100, 32'h200, 0, 0, 0, 0, 0, 0);
        idle(2);

        step(1, 32'h300, 32'h301, 1, 32'h400, 32'h401, 0, 0, 0);
        step(0, 0, 0, 1, 32'h400, 32'h401, 0, 0, 0);
        idle(3);

        step(1, 32'h40, 32'h80, 0, 0, 0, 0, 1, 32'h40);
        step(1, 32'h40, 32'hC0, 0, 0, 0, 0, 1, 32'h40);
        idle(3);

        for (int i = 0; i < 4; i++) step(1, 32'h40 + 32'(i * 4), 32'h900 + 32'(i), 0, 0, 0, 0, 1, 32'h40);
        step(1, 32'h60, 32'h960, 0, 0, 0, 0, 1, 32'h44);
        idle(6);

        step(1, 32'h80, 32'h88, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80);
        idle(2);

        for (int i = 0; i < 3; i++) step(1, 32'h10 + 32'(i * 4), 32'h500 + 32'(i), 0, 0, 0, 0, 1, 32'h10);
        step(1, 32'h20, 32'h520, 0, 0, 0, 1, 1, 32'h10);
        idle(2);

        for (int i = 0; i < 3; i++) step(1, 32'h10 + 32'(i * 4), 32'h600 + 32'(i), 0, 0, 0, 0, 1, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 i_rstn = 1'b0;
        #1 check_zero("midrst");
        q.delete();
        stall = 0;
        #1 i_rstn = 1'b1;
        idle(1);

        for (int n = 0; n < 400; n++) begin
            cs = 32'h100 + 32'($urandom_range(0, 5) * 4);
            ds = 32'h100 + 32'($urandom_range(0, 5) * 4);
            step(1'($urandom_range(0, 1)), cs, $urandom,
                 1'($urandom_range(0, 1)), ds, $urandom,
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                 32'h100 + 32'($urandom_range(0, 5) * 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ubtb_update_ctrl.md
# ubtb_update_ctrl

Update scheduler for the micro-BTB write port. It accepts branch-target training requests from two sources: commit-stage resolution, which has priority, and decode-stage correction. Requests are buffered in a small coalescing queue and drained one per cycle into the uBTB `i_ubtb_update` / `i_pc_jumpsrc` / `i_pc_jumpdst` port. A write is deferred while the fetch-side read targets the same uBTB index, but only for a bounded number of cycles.

## Interface
- `MXLEN`, default 32: PC width.
- `QDEPTH`, default 4: queue entries (power of 2, ≥2).
- `IDX_LSB`, default 2: lowest PC bit of the uBTB index.
- `IDX_W`, default 4: uBTB index width (log2 uBTB depth).
- `STALL_MAX`, default 3: maximum consecutive hazard deferrals before a forced write.

Ports:
- `i_clk` input 1: clock; all state updates on posedge.
- `i_rstn` input 1: asynchronous active-low reset.
- `i_cmt_valid` input 1: commit update request.
- `i_cmt_src` input MXLEN: commit branch PC.
- `i_cmt_dst` input MXLEN: commit target.
- `o_cmt_ready` output 1: commit request accepted this cycle if valid.
- `i_dec_valid` input 1: decode update request.
- `i_dec_src` input MXLEN: decode branch PC.
- `i_dec_dst` input MXLEN: decode target.
- `o_dec_ready` output 1: decode request accepted this cycle if valid.
- `i_flush` input 1: discard all queued updates.
- `i_pc_valid` input 1: uBTB read active this cycle.
- `i_pc` input MXLEN: uBTB read PC.
- `o_ubtb_update` output 1: write strobe to uBTB.
- `o_pc_jumpsrc` output MXLEN: write source PC (queue head).
- `o_pc_jumpdst` output MXLEN: write target (queue head).
- `o_q_count` output $clog2(QDEPTH)+1: occupied entries.

## Operation
- **Storage:** circular FIFO of {src, dst} with head/tail pointers and `count`. Pointers wrap modulo QDEPTH.
- **Ready:**
  - `o_cmt_ready = (count < QDEPTH) & ~i_flush & i_rstn`.
  - `o_dec_ready = o_cmt_ready & ~i_cmt_valid`.
  - Ready is based on the registered count only. A dequeue in the same cycle does not free a slot for that cycle's request.
- **Arbitration:** at most one accept per cycle; commit wins over decode. A decode request blocked by commit is held by the source and retried.
- **Coalescing:** an accepted request whose src equals the src of a valid entry that is not being dequeued this cycle overwrites that entry's dst. No enqueue occurs and count is unchanged. If the only match is the head being dequeued this cycle, the request enqueues normally at tail. At most one entry can match, by construction.
- **Issue:**
  - `hazard = i_pc_valid & (i_pc[IDX_LSB+:IDX_W] == head.src[IDX_LSB+:IDX_W])`.
  - `o_ubtb_update = (count != 0) & ~i_flush & (~hazard | stall_cnt == STALL_MAX)`.
  - `o_pc_jumpsrc` and `o_pc_jumpdst` always show the head entry, and read 0 when the queue is empty.
  - When `o_ubtb_update` is high, the head pops at the clock edge.
- **Stall counter:** width $clog2(STALL_MAX+1).
  - Increments on each cycle with count≠0, hazard, and no issue.
  - Clears on issue, when the queue is empty, and on flush.
- **Count update:** `count_next = count + enq − deq`. Enqueue and dequeue in the same cycle leave count unchanged.
- **Flush:** on `i_flush`, the next state has count=0, head=tail=0, and stall_cnt=0. No write issues and no request is accepted in the flush cycle.

## Timing
- **Reset (i_rstn low, asynchronous):**
  - count=0, head=tail=0, stall_cnt=0, entries cleared.
  - `o_ubtb_update=0`, `o_pc_jumpsrc`/`o_pc_jumpdst`=0, `o_q_count=0`.
  - `o_cmt_ready`/`o_dec_ready`=0.
  - After deassertion, both readys go to 1 once the reset is released.
- **Enqueue-to-write latency:** a request accepted at edge N can drive `o_ubtb_update` at the earliest in the cycle after edge N, i.e. 1 cycle. There is no bypass from input to output.
- **Coalesce visibility:** a coalesce into the head at edge N is visible on `o_pc_jumpdst` in the next cycle.
- **Throughput:** 1 accept and 1 write per cycle, sustained.
- **Full:** `o_cmt_ready` is low while count==QDEPTH. This holds even if a coalescing match exists.
- **Reset mid-operation:** all queued updates are lost. No partial write strobe is generated.

## Test plan
- **Reset, then a single commit request:** reset, then cmt src=0x100, dst=0x200 accepted at edge 1 → `o_ubtb_update=1` with 0x100/0x200 in cycle 2, `o_q_count` 1→0.
- **Arbitration:** cmt and dec valid in the same cycle → `o_cmt_ready=1`, `o_dec_ready=0`. The dec entry is accepted the next cycle; write order is cmt then dec.
- **Coalescing:** enqueue src=0x40 dst=0x80 while a hazard blocks issue, then src=0x40 dst=0xC0 → count stays 1 and the eventual write carries dst=0xC0.
- **Fill to QDEPTH=4:** enqueue 4 distinct srcs with `i_pc_valid` hazard on the head → ready low with count=4. Release the hazard → 4 writes on consecutive cycles, in FIFO order, with pointer wrap verified.
- **Starvation bound:** hold hazard continuously with STALL_MAX=3 → the write is deferred 3 cycles and forced on the 4th.
- **Flush with a pending request:** 3 entries queued, then `i_flush` with cmt valid → no write and no accept that cycle, next cycle count=0. An asynchronous reset pulse mid-drain yields all outputs 0 immediately.
